// File: rtl/exe_stage_unit.sv
// Execute stage: ALU, NZCV status register, branch target and the registered EXE/MEM boundary.
// One cycle from EXE inputs to *_out; freeze holds the boundary and status, flush inserts a bubble.
module exe_stage_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [3:0]       exe_cmd,
   input  logic             s_in,
   input  logic             b_in,
   input  logic             mem_read_in,
   input  logic             mem_write_in,
   input  logic             wb_en_in,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   input  logic [WIDTH-1:0] store_val,
   input  logic [3:0]       dest_in,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [23:0]      imm24,
   output logic             valid_out,
   output logic [WIDTH-1:0] alu_result_out,
   output logic [WIDTH-1:0] store_val_out,
   output logic [3:0]       dest_out,
   output logic             mem_read_out,
   output logic             mem_write_out,
   output logic             wb_en_out,
   output logic [3:0]       status,
   output logic             br_taken,
   output logic [WIDTH-1:0] br_addr
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   logic             c_cur;
   logic [WIDTH:0]   arith;
   logic [WIDTH-1:0] alu_res;
   logic             cmd_known;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic             status_we;
   logic [WIDTH-1:0] br_offset;

   assign c_cur = status[1];

   // Arithmetic runs one bit wider so the top bit is carry (add) or borrow (subtract).
   always_comb begin
      arith     = '0;
      alu_res   = '0;
      cmd_known = 1'b1;
      flag_c    = status[1];
      flag_v    = status[0];
      case (exe_cmd)
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_ADD, CMD_ADC: begin
            arith   = {1'b0, val1} + {1'b0, val2}
                    + {{WIDTH{1'b0}}, (exe_cmd == CMD_ADC) & c_cur};
            alu_res = arith[WIDTH-1:0];
            flag_c  = arith[WIDTH];
            flag_v  = (val1[WIDTH-1] == val2[WIDTH-1]) && (alu_res[WIDTH-1] != val1[WIDTH-1]);
         end
         CMD_SUB, CMD_SBC: begin
            arith   = {1'b0, val1} - {1'b0, val2}
                    - {{WIDTH{1'b0}}, (exe_cmd == CMD_SBC) & ~c_cur};
            alu_res = arith[WIDTH-1:0];
            flag_c  = ~arith[WIDTH];
            flag_v  = (val1[WIDTH-1] != val2[WIDTH-1]) && (alu_res[WIDTH-1] != val1[WIDTH-1]);
         end
         CMD_AND: alu_res = val1 & val2;
         CMD_ORR: alu_res = val1 | val2;
         CMD_EOR: alu_res = val1 ^ val2;
         default: cmd_known = 1'b0;
      endcase
      flag_n = alu_res[WIDTH-1];
      flag_z = (alu_res == '0);
   end

   assign status_we = valid_in & s_in & cmd_known & ~freeze & ~flush;

   // Branch target is word-aligned offset from PC+4; condition is resolved upstream.
   assign br_offset = {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};
   assign br_addr   = pc_in + br_offset;
   assign br_taken  = valid_in & b_in & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status <= 4'b0000;
      end else if (status_we) begin
         status <= {flag_n, flag_z, flag_c, flag_v};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_out      <= 1'b0;
         alu_result_out <= '0;
         store_val_out  <= '0;
         dest_out       <= 4'd0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         wb_en_out      <= 1'b0;
      end else if (flush) begin
         valid_out      <= 1'b0;
         alu_result_out <= '0;
         store_val_out  <= '0;
         dest_out       <= 4'd0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         wb_en_out      <= 1'b0;
      end else if (!freeze) begin
         valid_out      <= valid_in;
         alu_result_out <= alu_res;
         store_val_out  <= store_val;
         dest_out       <= dest_in;
         mem_read_out   <= valid_in & mem_read_in;
         mem_write_out  <= valid_in & mem_write_in;
         wb_en_out      <= valid_in & wb_en_in;
      end
   end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed and randomized checks of exe_stage_unit against an arithmetic reference model.
module tb_exe_stage_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, flush, valid_in, s_in, b_in;
   logic        mem_read_in, mem_write_in, wb_en_in;
   logic [3:0]  exe_cmd, dest_in;
   logic [31:0] val1, val2, store_val, pc_in;
   logic [23:0] imm24;
   logic        valid_out, mem_read_out, mem_write_out, wb_en_out, br_taken;
   logic [31:0] alu_result_out, store_val_out, br_addr;
   logic [3:0]  dest_out, status;

   int checks = 0;
   int errors = 0;

   // reference model of the EXE/MEM register and NZCV
   logic        m_valid, m_mr, m_mw, m_wb;
   logic [31:0] m_res, m_sv;
   logic [3:0]  m_dest, m_status;

   exe_stage_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
      .exe_cmd(exe_cmd), .s_in(s_in), .b_in(b_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .wb_en_in(wb_en_in), .val1(val1), .val2(val2),
      .store_val(store_val), .dest_in(dest_in), .pc_in(pc_in), .imm24(imm24),
      .valid_out(valid_out), .alu_result_out(alu_result_out), .store_val_out(store_val_out),
      .dest_out(dest_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .wb_en_out(wb_en_out), .status(status), .br_taken(br_taken), .br_addr(br_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] st, output logic [31:0] res,
                          output logic [3:0] nst, output bit known);
      longint unsigned ua, ub, u;
      longint sa, sb, sr;
      int cin, bi;
      bit arith, c, v;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      cin = st[1] ? 1 : 0;
      bi = 1 - cin;
      known = 1; arith = 0; c = st[1]; v = st[0]; res = 0; sr = 0;
      case (cmd)
         4'd1: res = b;
         4'd9: res = ~b;
         4'd2: begin u = ua + ub; res = u[31:0]; c = (u >= 64'h1_0000_0000); sr = sa + sb; arith = 1; end
         4'd3: begin u = ua + ub + cin; res = u[31:0]; c = (u >= 64'h1_0000_0000); sr = sa + sb + cin; arith = 1; end
         4'd4: begin res = a - b; c = (ua >= ub); sr = sa - sb; arith = 1; end
         4'd5: begin res = a - b - bi; c = (ua >= ub + bi); sr = sa - sb - bi; arith = 1; end
         4'd6: res = a & b;
         4'd7: res = a | b;
         4'd8: res = a ^ b;
         default: known = 0;
      endcase
      if (arith) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      nst = known ? {res[31], (res == 32'd0), c, v} : st;
   endtask

   task automatic drive(input logic v, input logic [3:0] cmd, input logic s, input logic b,
                        input logic mr, input logic mw, input logic wb,
                        input logic [31:0] a, input logic [31:0] bb, input logic [31:0] sv,
                        input logic [3:0] d, input logic frz, input logic fl);
      valid_in = v; exe_cmd = cmd; s_in = s; b_in = b;
      mem_read_in = mr; mem_write_in = mw; wb_en_in = wb;
      val1 = a; val2 = bb; store_val = sv; dest_in = d;
      freeze = frz; flush = fl;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"},  {31'd0, valid_out},     {31'd0, m_valid});
      chk({tag, ".result"}, alu_result_out,          m_res);
      chk({tag, ".store"},  store_val_out,           m_sv);
      chk({tag, ".dest"},   {28'd0, dest_out},       {28'd0, m_dest});
      chk({tag, ".mr"},     {31'd0, mem_read_out},  {31'd0, m_mr});
      chk({tag, ".mw"},     {31'd0, mem_write_out}, {31'd0, m_mw});
      chk({tag, ".wb"},     {31'd0, wb_en_out},     {31'd0, m_wb});
      chk({tag, ".status"}, {28'd0, status},         {28'd0, m_status});
   endtask

   // Checks the combinational branch outputs, clocks once, then checks the registered state.
   task automatic step(input string tag);
      logic [31:0] res, exp_addr;
      logic [3:0]  nst;
      bit          known;
      int          off;
      #1;
      off = int'(imm24);
      if (imm24 >= 24'h800000) off = off - (1 << 24);
      exp_addr = pc_in + 32'(off * 4);
      chk({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, valid_in & b_in & ~flush});
      chk({tag, ".br_addr"}, br_addr, exp_addr);
      ref_alu(exe_cmd, val1, val2, m_status, res, nst, known);
      @(posedge clk);
      if (flush) begin
         m_valid = 0; m_res = 0; m_sv = 0; m_dest = 0; m_mr = 0; m_mw = 0; m_wb = 0;
      end else if (!freeze) begin
         if (valid_in && s_in && known) m_status = nst;
         m_valid = valid_in; m_res = res; m_sv = store_val; m_dest = dest_in;
         m_mr = valid_in & mem_read_in; m_mw = valid_in & mem_write_in; m_wb = valid_in & wb_en_in;
      end
      #1;
      check_model(tag);
   endtask

   task automatic model_clear();
      m_valid = 0; m_res = 0; m_sv = 0; m_dest = 0; m_mr = 0; m_mw = 0; m_wb = 0; m_status = 0;
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] edges [5];
      edges = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      rst = 1'b0;
      pc_in = 32'h0; imm24 = 24'h0;
      drive(0, 4'd0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0, 0, 0);
      model_clear();
      #2;
      check_model("reset");
      rst = 1'b1;
      step("idle");

      drive(1, 4'd2, 1, 0, 0, 0, 1, 32'h7FFFFFFF, 32'd1, 32'd0, 4'd3, 0, 0);
      step("adds");
      chk("adds_res", alu_result_out, 32'h80000000);
      chk("adds_nzcv", {28'd0, status}, 32'h9);

      drive(1, 4'd3, 1, 0, 0, 0, 1, 32'd1, 32'd1, 32'd0, 4'd4, 0, 0);
      step("adc");
      chk("adc_res", alu_result_out, 32'd2);
      chk("adc_c", {31'd0, status[1]}, 32'd0);

      drive(1, 4'd4, 1, 0, 0, 0, 0, 32'd5, 32'd5, 32'd0, 4'd0, 0, 0);
      step("subs");
      chk("subs_res", alu_result_out, 32'd0);
      chk("subs_nzcv", {28'd0, status}, 32'h6);

      drive(1, 4'd5, 0, 0, 0, 0, 1, 32'd3, 32'd1, 32'd0, 4'd6, 0, 0);
      step("sbc");
      chk("sbc_res", alu_result_out, 32'd2);
      chk("sbc_nzcv", {28'd0, status}, 32'h6);

      drive(1, 4'd4, 1, 0, 0, 0, 0, 32'h80000000, 32'd1, 32'd0, 4'd0, 0, 0);
      step("subs_ovf");
      chk("subs_ovf_nzcv", {28'd0, status}, 32'h3);

      drive(1, 4'd6, 1, 0, 0, 0, 0, 32'hF0, 32'h0F, 32'd0, 4'd0, 0, 0);
      step("ands");
      chk("ands_res", alu_result_out, 32'd0);
      chk("ands_nzcv", {28'd0, status}, 32'h7);

      drive(1, 4'd12, 1, 0, 0, 0, 1, 32'h5, 32'h7, 32'd0, 4'd2, 0, 0);
      step("unknown");
      chk("unknown_res", alu_result_out, 32'd0);
      chk("unknown_nzcv", {28'd0, status}, 32'h7);

      drive(1, 4'd2, 0, 0, 0, 1, 0, 32'h1000, 32'd8, 32'hDEAD, 4'd1, 0, 0);
      step("str");
      chk("str_addr", alu_result_out, 32'h1008);
      chk("str_mw", {31'd0, mem_write_out}, 32'd1);
      drive(1, 4'd2, 1, 0, 1, 0, 1, 32'd1, 32'd1, 32'h0, 4'd9, 1, 0);
      step("freeze1");
      step("freeze2");
      chk("freeze_addr", alu_result_out, 32'h1008);
      chk("freeze_store", store_val_out, 32'hDEAD);
      chk("freeze_nzcv", {28'd0, status}, 32'h7);
      flush = 1'b1;
      step("flush_frz");
      chk("flush_valid", {31'd0, valid_out}, 32'd0);
      chk("flush_mw", {31'd0, mem_write_out}, 32'd0);
      chk("flush_nzcv", {28'd0, status}, 32'h7);

      drive(0, 4'd2, 0, 1, 1, 1, 1, 32'd7, 32'd8, 32'h55, 4'd7, 0, 0);
      step("bubble");
      chk("bubble_wb", {31'd0, wb_en_out}, 32'd0);

      drive(1, 4'd0, 0, 1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0, 0, 0);
      pc_in = 32'h100; imm24 = 24'hFFFFFE;
      #1;
      chk("br_taken", {31'd0, br_taken}, 32'd1);
      chk("br_addr", br_addr, 32'hF8);
      flush = 1'b1;
      #1;
      chk("br_flush", {31'd0, br_taken}, 32'd0);
      step("br_flushed");

      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), pick(), pick(), $urandom,
               4'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
         pc_in = $urandom; imm24 = 24'($urandom);
         step("rand");
      end

      drive(1, 4'd2, 1, 0, 0, 0, 1, 32'h11, 32'h22, 32'h99, 4'd5, 0, 0);
      step("pre_rst");
      chk("pre_rst_res", alu_result_out, 32'h33);
      drive(0, 4'd0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0, 0, 0);
      #2;
      rst = 1'b0;
      model_clear();
      #1;
      check_model("async_rst");
      chk("rst_br", {31'd0, br_taken}, 32'd0);
      #2;
      rst = 1'b1;
      drive(1, 4'd1, 1, 0, 0, 0, 1, 32'd0, 32'hFFFFFFFF, 32'd0, 4'd8, 0, 0);
      step("post_rst");
      chk("post_rst_res", alu_result_out, 32'hFFFFFFFF);
      chk("post_rst_nzcv", {28'd0, status}, 32'h8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_stage_unit.md
# exe_stage_unit

Execute stage of the 5-stage ARM-subset pipeline. It consumes the EXE_CMD code and the S, B, mem_read, mem_write and WB_Enable signals produced by the decode-stage control unit, together with the operands from the ID/EXE register. It computes the ALU result and branch target, owns the NZCV status register, and drives the registered EXE/MEM boundary, with freeze (stall) and flush support.

## Interface
- WIDTH, 32, datapath width for operands, result and PC.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset. Low clears all state immediately.
- freeze  in  1  hazard stall. EXE/MEM register and status hold.
- flush  in  1  squash the instruction in EXE. Wins over freeze.
- valid_in  in  1  EXE holds a real instruction. 0 means bubble.
- exe_cmd  in  4  ALU command from the decoder.
- s_in  in  1  update status.
- b_in  in  1  branch instruction.
- mem_read_in, mem_write_in, wb_en_in  in  1 each  control passed down the pipe.
- val1, val2  in  WIDTH  operands: Rn and shifter operand.
- store_val  in  WIDTH  Rm value for STR.
- dest_in  in  4  destination register.
- pc_in  in  WIDTH  PC+4 of the instruction.
- imm24  in  24  branch offset field.
- valid_out  out  1  EXE/MEM holds a real instruction.
- alu_result_out, store_val_out  out  WIDTH  registered result and store data.
- dest_out  out  4  registered destination.
- mem_read_out, mem_write_out, wb_en_out  out  1 each  registered controls.
- status  out  4  NZCV; bit3=N, bit0=V.
- br_taken  out  1  combinational branch request to fetch.
- br_addr  out  WIDTH  combinational branch target.

## Operation
- Command decode, with C as the current status C:
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD: val1+val2. Also used for LDR/STR address.
  - 0011 ADC: val1+val2+C.
  - 0100 SUB/CMP: val1-val2.
  - 0101 SBC: val1-val2-(~C).
  - 0110 AND/TST: val1&val2.
  - 0111 ORR: val1|val2.
  - 1000 EOR: val1^val2.
  - Any other code: result 0 and no status update, even with s_in=1.
- Arithmetic runs at WIDTH+1 bits.
  - ADD/ADC: C = carry out.
  - SUB/SBC: C = NOT borrow.
  - V = signed overflow, i.e. operand signs agree (ADD) or differ (SUB) and the result sign differs from val1.
- Flags for logical and MOV/MVN commands: N = result[WIDTH-1], Z = (result==0). C and V keep their old values.
- Status update enable: valid_in & s_in & known cmd & ~freeze & ~flush. Write happens at the clock edge.
- Branch outputs:
  - br_taken = valid_in & b_in & ~flush.
  - br_addr = pc_in + (sign-extended imm24 << 2), truncated to WIDTH.
  - No condition evaluation in this block.
- EXE/MEM register update rules:
  - flush: valid_out, mem_read_out, mem_write_out and wb_en_out go to 0. Data fields are don't-care (cleared to 0).
  - freeze without flush: every output register holds.
  - Otherwise: capture the computed result and inputs.
  - valid_in=0: capture with all controls forced to 0.
- Compare and test operations set WB_Enable=0 in the decoder; this block passes wb_en through unchanged.

## Timing
- ALU result is registered at the EXE/MEM register: 1-cycle latency from EXE inputs to *_out.
- Status written at the edge ending the setting instruction. A flag consumer in the next cycle (ADC/SBC, or a conditional in ID) sees the new value, so no flag forwarding is needed.
- br_taken and br_addr are valid in the same cycle the branch sits in EXE. Fetch redirects at the next edge.
- Reset (rst low, asynchronous): all *_out = 0, valid_out = 0, status = 4'b0000. br_taken is 0 because it is gated on valid_in, which upstream reset also clears.
- Deasserting reset mid-pipeline: the first edge after release captures normally.
- freeze and flush together: flush wins, a bubble is inserted and status is not written.

## Test plan
- Reset: assert rst low mid-cycle with outputs non-zero -> all outputs and status become 0 immediately, with no clock edge needed.
- ADDS 0x7FFFFFFF+1 -> next cycle alu_result_out = 0x80000000, status = N1 Z0 C0 V1. Follow with ADC 1+1 -> result 2, C is 0.
- SUBS 5-5 -> result 0, status = Z1 C1. Then SBC 3-1 with C=1 -> result 2, no status change because s_in=0.
- ANDS 0xF0 & 0x0F with prior C=1 and V=1 -> result 0, status = 4'b0111: N0 Z1, C and V retained.
- STR with freeze held 2 cycles -> outputs and status frozen. Then flush together with freeze -> valid_out=0, mem_write_out=0, status unchanged.
- Branch with pc_in=0x100 and imm24=0xFFFFFE -> br_taken=1 and br_addr=0xF8 in the same cycle. With flush=1 -> br_taken=0.
